// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared codes, FSM encoding and geometry for the data cache
package data_cache_pkg;

  localparam int LINES    = 8;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 25;
  localparam int BLOCK_W  = 128;
  localparam int OFFSET_W = 4;
  localparam int BLKADR_W = 32 - OFFSET_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2
  } state_e;

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU-side request and main-memory block bus of the data cache
interface data_cache_if;
  import data_cache_pkg::*;

  logic                mem_read;
  logic                mem_write;
  logic [2:0]          funct3;
  logic [31:0]         address;
  logic [31:0]         write_data;
  logic [31:0]         read_data;
  logic                busywait;
  logic                main_mem_read;
  logic                main_mem_write;
  logic [BLKADR_W-1:0] main_mem_address;
  logic [BLOCK_W-1:0]  main_mem_writedata;
  logic [BLOCK_W-1:0]  main_mem_readdata;
  logic                main_mem_busywait;

  modport slave (
    input  mem_read, mem_write, funct3, address, write_data,
    input  main_mem_readdata, main_mem_busywait,
    output read_data, busywait,
    output main_mem_read, main_mem_write, main_mem_address, main_mem_writedata
  );

  modport master (
    output mem_read, mem_write, funct3, address, write_data,
    output main_mem_readdata, main_mem_busywait,
    input  read_data, busywait,
    input  main_mem_read, main_mem_write, main_mem_address, main_mem_writedata
  );

endinterface

// File: rtl/data_cache_mem_align.sv
// rtl/data_cache_mem_align.sv - load lane extract/extend and store lane merge on one cache line
module mem_align
  import data_cache_pkg::*;
(
  input  logic [2:0]         funct3,
  input  logic [3:0]         addr_lo,
  input  logic [BLOCK_W-1:0] line,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [BLOCK_W-1:0] merged
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  lane_mask;
  logic [31:0] wrep;
  logic [15:0] byte_en;

  always_comb begin
    word     = line[{addr_lo[3:2], 5'b00000} +: 32];
    byte_sel = word[{addr_lo[1:0], 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'h000000, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'h0000, half_sel};
      default: rdata = word;
    endcase
  end

  // Store data is replicated across lanes so the byte enable alone picks the target bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << addr_lo[1:0];
        wrep      = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep      = {2{wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        wrep      = wdata;
      end
    endcase
    byte_en = {12'h000, lane_mask} << {addr_lo[3:2], 2'b00};
    merged  = line;
    for (int i = 0; i < 16; i++) begin
      if (byte_en[i]) merged[i*8 +: 8] = wrep[(i%4)*8 +: 8];
    end
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back, write-allocate data cache (8 x 128-bit lines)
module data_cache
  import data_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  data_cache_if.slave bus
);

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [TAG_W-1:0]     tag_d  [LINES];
  logic [BLOCK_W-1:0]   data_q [LINES];
  logic [BLOCK_W-1:0]   data_d [LINES];

  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic                 request;
  logic                 hit;
  logic [BLOCK_W-1:0]   line;
  logic [BLOCK_W-1:0]   merged_line;
  logic [31:0]          load_word;

  assign idx     = bus.address[6:4];
  assign tag     = bus.address[31:7];
  assign request = bus.mem_read | bus.mem_write;
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign line    = data_q[idx];

  mem_align u_align (
    .funct3 (bus.funct3),
    .addr_lo(bus.address[3:0]),
    .line   (line),
    .wdata  (bus.write_data),
    .rdata  (load_word),
    .merged (merged_line)
  );

  assign bus.busywait  = request && ((state_q != ST_IDLE) || !hit);
  // A simultaneous read and write is a store, so no load data is returned for it.
  assign bus.read_data = (bus.mem_read && !bus.mem_write && hit && state_q == ST_IDLE)
                         ? load_word : 32'h0;

  always_comb begin
    state_d                = state_q;
    valid_d                = valid_q;
    dirty_d                = dirty_q;
    tag_d                  = tag_q;
    data_d                 = data_q;
    bus.main_mem_read      = 1'b0;
    bus.main_mem_write     = 1'b0;
    bus.main_mem_address   = '0;
    bus.main_mem_writedata = '0;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          if (hit) begin
            if (bus.mem_write) begin
              data_d[idx]  = merged_line;
              dirty_d[idx] = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        bus.main_mem_write     = 1'b1;
        bus.main_mem_address   = {tag_q[idx], idx};
        bus.main_mem_writedata = line;
        if (!bus.main_mem_busywait) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        bus.main_mem_read    = 1'b1;
        bus.main_mem_address = bus.address[31:4];
        if (!bus.main_mem_busywait) begin
          data_d[idx]  = bus.main_mem_readdata;
          tag_d[idx]   = tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays keep their contents across reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;
  import data_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  localparam logic [127:0] BLK_A   = {32'h0BADC0DE, 32'hCAFEF00D, 32'h800000FF, 32'h800000FF};
  localparam logic [127:0] BLK_A_M = {32'h0BADC0DE, 32'hCAFEF00D, 32'h800000FF, 32'h567800FF};
  localparam logic [127:0] BLK_B   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h13579BDF};
  localparam logic [127:0] BLK_A_S = {32'h0BADC0DE, 32'hCAFEF00D, 32'hAABBCCDD, 32'h800000FF};

  data_cache_if bus_if ();

  data_cache dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      assert (!(bus_if.main_mem_read && bus_if.main_mem_write)) else begin
        n_bad++;
        $error("FAIL mm_excl: observed rd=%0b wr=%0b expected not both", bus_if.main_mem_read,
               bus_if.main_mem_write);
      end
    end
  end

  task automatic set_req(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3);
    bus_if.mem_read  = rd;
    bus_if.mem_write = wr;
    bus_if.address   = a;
    bus_if.funct3    = f3;
  endtask

  initial begin
    rst_n                    = 1'b0;
    bus_if.mem_read          = 1'b0;
    bus_if.mem_write         = 1'b0;
    bus_if.funct3            = 3'b000;
    bus_if.address           = 32'h0;
    bus_if.write_data        = 32'h0;
    bus_if.main_mem_readdata = '0;
    bus_if.main_mem_busywait = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busywait", 128'(bus_if.busywait), 128'(1'b0));
    chk("rst_read_data", 128'(bus_if.read_data), 128'h0);
    chk("rst_mm_read", 128'(bus_if.main_mem_read), 128'(1'b0));
    chk("rst_mm_write", 128'(bus_if.main_mem_write), 128'(1'b0));
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Cold miss on 0x40, fetch block 0x4.
    @(negedge clk);
    set_req(1'b1, 1'b0, 32'h40, F3_W);
    #1;
    chk("miss_busywait", 128'(bus_if.busywait), 128'(1'b1));
    chk("miss_idle_mm_read", 128'(bus_if.main_mem_read), 128'(1'b0));
    @(negedge clk);
    #1;
    chk("fetch_mm_read", 128'(bus_if.main_mem_read), 128'(1'b1));
    chk("fetch_addr", 128'(bus_if.main_mem_address), 128'h4);
    chk("fetch_busywait", 128'(bus_if.busywait), 128'(1'b1));
    bus_if.main_mem_readdata = BLK_A;
    bus_if.main_mem_busywait = 1'b0;
    @(negedge clk);
    bus_if.main_mem_busywait = 1'b1;
    #1;
    chk("refill_busywait", 128'(bus_if.busywait), 128'(1'b0));
    chk("refill_rdata", 128'(bus_if.read_data), 128'h800000FF);
    chk("refill_mm_read", 128'(bus_if.main_mem_read), 128'(1'b0));

    // Sized loads on the resident line.
    @(negedge clk); set_req(1'b1, 1'b0, 32'h47, F3_B);  #1;
    chk("lb_47", 128'(bus_if.read_data), 128'hFFFFFF80);
    chk("lb_47_stall", 128'(bus_if.busywait), 128'(1'b0));
    @(negedge clk); set_req(1'b1, 1'b0, 32'h47, F3_BU); #1;
    chk("lbu_47", 128'(bus_if.read_data), 128'h00000080);
    @(negedge clk); set_req(1'b1, 1'b0, 32'h46, F3_H);  #1;
    chk("lh_46", 128'(bus_if.read_data), 128'hFFFF8000);
    @(negedge clk); set_req(1'b1, 1'b0, 32'h46, F3_HU); #1;
    chk("lhu_46", 128'(bus_if.read_data), 128'h00008000);
    @(negedge clk); set_req(1'b1, 1'b0, 32'h44, F3_B);  #1;
    chk("lb_44", 128'(bus_if.read_data), 128'hFFFFFFFF);
    @(negedge clk); set_req(1'b1, 1'b0, 32'h44, F3_BU); #1;
    chk("lbu_44", 128'(bus_if.read_data), 128'h000000FF);
    @(negedge clk); set_req(1'b1, 1'b0, 32'h47, F3_W);  #1;
    chk("lw_47", 128'(bus_if.read_data), 128'h800000FF);
    @(negedge clk); set_req(1'b0, 1'b0, 32'h44, F3_W);  #1;
    chk("noreq_rdata", 128'(bus_if.read_data), 128'h0);
    chk("noreq_busywait", 128'(bus_if.busywait), 128'(1'b0));

    // Halfword store hit into lanes 2..3 of word0.
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'h42, F3_H);
    bus_if.write_data = 32'h12345678;
    #1;
    chk("sh_busywait", 128'(bus_if.busywait), 128'(1'b0));
    @(negedge clk); set_req(1'b1, 1'b0, 32'h40, F3_W); #1;
    chk("sh_merge_w0", 128'(bus_if.read_data), 128'h567800FF);
    @(negedge clk); set_req(1'b1, 1'b0, 32'h44, F3_W); #1;
    chk("sh_keep_w1", 128'(bus_if.read_data), 128'h800000FF);

    // Conflict miss on dirty line: writeback then fetch.
    @(negedge clk); set_req(1'b1, 1'b0, 32'h440, F3_W); #1;
    chk("conf_busywait", 128'(bus_if.busywait), 128'(1'b1));
    @(negedge clk); #1;
    chk("wb_mm_write", 128'(bus_if.main_mem_write), 128'(1'b1));
    chk("wb_mm_read", 128'(bus_if.main_mem_read), 128'(1'b0));
    chk("wb_addr", 128'(bus_if.main_mem_address), 128'h4);
    chk("wb_data", bus_if.main_mem_writedata, BLK_A_M);
    @(negedge clk); #1;
    chk("wb_hold", 128'(bus_if.main_mem_write), 128'(1'b1));
    bus_if.main_mem_busywait = 1'b0;
    @(negedge clk); #1;
    chk("conf_fetch_rd", 128'(bus_if.main_mem_read), 128'(1'b1));
    chk("conf_fetch_wr", 128'(bus_if.main_mem_write), 128'(1'b0));
    chk("conf_fetch_addr", 128'(bus_if.main_mem_address), 128'h44);
    bus_if.main_mem_readdata = BLK_B;
    @(negedge clk);
    bus_if.main_mem_busywait = 1'b1;
    #1;
    chk("conf_hit_busy", 128'(bus_if.busywait), 128'(1'b0));
    chk("conf_hit_rdata", 128'(bus_if.read_data), 128'h13579BDF);

    // Reset in the middle of a fetch.
    @(negedge clk); set_req(1'b1, 1'b0, 32'h40, F3_W); #1;
    chk("rf_busywait", 128'(bus_if.busywait), 128'(1'b1));
    @(negedge clk); #1;
    chk("rf_fetching", 128'(bus_if.main_mem_read), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rf_rst_mm_read", 128'(bus_if.main_mem_read), 128'(1'b0));
    chk("rf_rst_mm_write", 128'(bus_if.main_mem_write), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rf_remiss", 128'(bus_if.busywait), 128'(1'b1));
    chk("rf_remiss_idle", 128'(bus_if.main_mem_read), 128'(1'b0));
    @(negedge clk); #1;
    chk("rf_refetch", 128'(bus_if.main_mem_read), 128'(1'b1));
    chk("rf_refetch_addr", 128'(bus_if.main_mem_address), 128'h4);
    bus_if.main_mem_readdata = BLK_A;
    bus_if.main_mem_busywait = 1'b0;
    @(negedge clk);
    bus_if.main_mem_busywait = 1'b1;
    #1;
    chk("rf_hit_rdata", 128'(bus_if.read_data), 128'h800000FF);

    // Read and write together on a hit behave as a store.
    @(negedge clk);
    set_req(1'b1, 1'b1, 32'h44, F3_W);
    bus_if.write_data = 32'hAABBCCDD;
    #1;
    chk("rw_busywait", 128'(bus_if.busywait), 128'(1'b0));
    @(negedge clk); set_req(1'b1, 1'b0, 32'h44, F3_W); #1;
    chk("rw_stored", 128'(bus_if.read_data), 128'hAABBCCDD);
    @(negedge clk); set_req(1'b1, 1'b0, 32'h440, F3_W); #1;
    chk("rw_dirty_miss", 128'(bus_if.busywait), 128'(1'b1));
    @(negedge clk); #1;
    chk("rw_dirty_wb", 128'(bus_if.main_mem_write), 128'(1'b1));
    chk("rw_dirty_wb_data", bus_if.main_mem_writedata, BLK_A_S);

    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h0, F3_W);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
